// File: rtl/jtframe_snd_interp.sv
// Sound bridge into the clk_dac domain: captures toggle-flagged stereo samples, measures the
// sample period in DAC enable ticks and ramps linearly between consecutive samples.
module jtframe_snd_interp #(
  parameter logic SIGNED_SND = 1'b0,
  parameter int   PER_W      = 10,
  parameter int   MIN_PER    = 8
) (
  input  logic             rst,
  input  logic             clk_dac,
  input  logic [15:0]      snd_left,
  input  logic [15:0]      snd_right,
  input  logic             snd_tgl,
  output logic             cen_dac,
  output logic [19:0]      pcm_left,
  output logic [19:0]      pcm_right,
  output logic [PER_W-1:0] period,
  output logic             overrun
);
  typedef enum logic [1:0] {IDLE, DIV, RUN} state_t;

  localparam logic [PER_W-1:0] ONE   = PER_W'(1);
  localparam logic [PER_W-1:0] MIN_P = PER_W'(MIN_PER);

  state_t              state;
  logic [1:0]          cnt;
  logic                sync1, sync2, hist, ev;
  logic [PER_W-1:0]    tick_cnt, step_cnt, meas, new_per;
  logic [4:0]          div_cnt;
  logic signed [15:0]  x_l, x_r, cur_l, cur_r;
  logic signed [16:0]  d_l, d_r;
  logic [15:0]         mag_l, mag_r;
  logic signed [23:0]  acc_l, acc_r, step_l, step_r;
  logic [23:0]         num_l, num_r, quo_l, quo_r;
  logic [PER_W-1:0]    rem_l, rem_r;
  logic                neg_l, neg_r;
  logic [PER_W+23:0]   it_l, it_r;

  // One restoring-division step: returns {remainder, quotient} after shifting in num_msb.
  function automatic logic [PER_W+23:0] div_iter(input logic [PER_W-1:0] rem, input logic num_msb,
                                                 input logic [23:0] quo, input logic [PER_W-1:0] dv);
    logic [PER_W+1:0] trial;
    trial = {1'b0, rem, num_msb} - {2'b00, dv};
    if (trial[PER_W+1]) div_iter = {rem[PER_W-2:0], num_msb, quo[22:0], 1'b0};
    else                div_iter = {trial[PER_W-1:0], quo[22:0], 1'b1};
  endfunction

  assign cen_dac = (cnt == 2'd3);
  assign ev      = sync2 ^ hist;
  assign x_l     = SIGNED_SND ? snd_left  : (snd_left  ^ 16'h8000);
  assign x_r     = SIGNED_SND ? snd_right : (snd_right ^ 16'h8000);
  assign d_l     = {x_l[15], x_l} - {cur_l[15], cur_l};
  assign d_r     = {x_r[15], x_r} - {cur_r[15], cur_r};
  assign mag_l   = d_l[16] ? 16'(-d_l) : d_l[15:0];
  assign mag_r   = d_r[16] ? 16'(-d_r) : d_r[15:0];

  // A tick landing in the same cycle as ev still belongs to the period being closed.
  always_comb begin
    meas = tick_cnt;
    if (cen_dac && tick_cnt != '1) meas = tick_cnt + ONE;
    new_per = (meas == '0) ? ONE : meas;
    it_l = div_iter(rem_l, num_l[23], quo_l, period);
    it_r = div_iter(rem_r, num_r[23], quo_r, period);
  end

  always_ff @(posedge clk_dac or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      hist      <= 1'b0;
      tick_cnt  <= '0;
      step_cnt  <= '0;
      period    <= '0;
      div_cnt   <= 5'd0;
      cur_l     <= '0;
      cur_r     <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      step_l    <= '0;
      step_r    <= '0;
      num_l     <= '0;
      num_r     <= '0;
      quo_l     <= '0;
      quo_r     <= '0;
      rem_l     <= '0;
      rem_r     <= '0;
      neg_l     <= 1'b0;
      neg_r     <= 1'b0;
      overrun   <= 1'b0;
      pcm_left  <= 20'h40000;
      pcm_right <= 20'h40000;
    end else begin
      cnt       <= cnt + 2'd1;
      sync1     <= snd_tgl;
      sync2     <= sync1;
      hist      <= sync2;
      overrun   <= ev && (state == DIV);
      pcm_left  <= {1'b0, acc_l[23:8] ^ 16'h8000, 3'b000};
      pcm_right <= {1'b0, acc_r[23:8] ^ 16'h8000, 3'b000};
      if (ev) begin
        cur_l    <= x_l;
        cur_r    <= x_r;
        period   <= new_per;
        tick_cnt <= '0;
        if (new_per < MIN_P) begin
          acc_l <= {x_l, 8'h00};
          acc_r <= {x_r, 8'h00};
          state <= IDLE;
        end else begin
          // The outgoing cur becomes prev: the ramp starts where the last one was heading.
          acc_l    <= {cur_l, 8'h00};
          acc_r    <= {cur_r, 8'h00};
          step_l   <= '0;
          step_r   <= '0;
          num_l    <= {mag_l, 8'h00};
          num_r    <= {mag_r, 8'h00};
          neg_l    <= d_l[16];
          neg_r    <= d_r[16];
          rem_l    <= '0;
          rem_r    <= '0;
          quo_l    <= '0;
          quo_r    <= '0;
          div_cnt  <= 5'd0;
          step_cnt <= '0;
          state    <= DIV;
        end
      end else begin
        if (cen_dac && tick_cnt != '1) tick_cnt <= tick_cnt + ONE;
        case (state)
          DIV: begin
            rem_l   <= it_l[PER_W+23:24];
            rem_r   <= it_r[PER_W+23:24];
            quo_l   <= it_l[23:0];
            quo_r   <= it_r[23:0];
            num_l   <= num_l << 1;
            num_r   <= num_r << 1;
            div_cnt <= div_cnt + 5'd1;
            if (div_cnt == 5'd23) begin
              step_l   <= neg_l ? (24'd0 - it_l[23:0]) : it_l[23:0];
              step_r   <= neg_r ? (24'd0 - it_r[23:0]) : it_r[23:0];
              step_cnt <= '0;
              state    <= RUN;
            end
          end
          RUN: begin
            if (cen_dac) begin
              step_cnt <= step_cnt + ONE;
              if (step_cnt + ONE == period) begin
                acc_l <= {cur_l, 8'h00};
                acc_r <= {cur_r, 8'h00};
                state <= IDLE;
              end else begin
                acc_l <= acc_l + step_l;
                acc_r <= acc_r + step_r;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
